// File: rtl/alu_seq_accumulator_pkg.sv
// Shared encodings for the sequential ALU/accumulator.
// Mode and FSM state constants are width-independent.
package alu_seq_accumulator_pkg;

  localparam logic [2:0] MODE_A       = 3'b000;
  localparam logic [2:0] MODE_B       = 3'b001;
  localparam logic [2:0] MODE_ADD     = 3'b010;
  localparam logic [2:0] MODE_SUB     = 3'b011;
  localparam logic [2:0] MODE_ACC_ADD = 3'b100;
  localparam logic [2:0] MODE_ACC_SUB = 3'b101;
  localparam logic [2:0] MODE_MUL     = 3'b110;
  localparam logic [2:0] MODE_CLR     = 3'b111;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/alu_seq_accumulator_mul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// done/product present the final step combinationally on the last cycle.
module shift_add_multiplier
  import alu_seq_accumulator_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] part;
  logic [2*WIDTH-1:0] part_next;
  logic [WIDTH-1:0]   mplr;
  logic [CW-1:0]      count;

  assign part_next = mplr[0] ? part + mcand : part;
  assign done      = (count == CW'(1));
  assign product   = part_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand <= '0;
      part  <= '0;
      mplr  <= '0;
      count <= '0;
    end else if (start) begin
      mcand <= {{WIDTH{1'b0}}, a};
      part  <= '0;
      mplr  <= b;
      count <= CW'(WIDTH);
    end else if (count != '0) begin
      part  <= part_next;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq_accumulator.sv
// Registered ALU with accumulator, flags and valid/ready handshakes.
// Multiply runs on the shift-add sub-unit; everything else is one cycle.
module alu_seq_accumulator
  import alu_seq_accumulator_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             is_zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic [WIDTH-1:0] acc
);

  logic [0:0]         state;
  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   op_x;
  logic [WIDTH-1:0]   op_z;
  logic [WIDTH:0]     ext;
  logic [WIDTH-1:0]   res;
  logic               res_c;
  logic               res_v;
  logic               ovf;

  assign in_ready  = !reset && (state == ST_IDLE)
                     && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (mode == MODE_MUL);
  assign is_zero   = (y == '0);
  assign negative  = y[WIDTH-1];

  // mode[2] swaps in acc as the left operand, mode[0] selects subtract
  always_comb begin
    op_x = mode[2] ? acc : a;
    op_z = mode[2] ? a : b;
    ext  = mode[0] ? {1'b0, op_x} - {1'b0, op_z}
                   : {1'b0, op_x} + {1'b0, op_z};
    ovf  = (ext[WIDTH-1] != op_x[WIDTH-1])
           && ((op_x[WIDTH-1] != op_z[WIDTH-1]) == mode[0]);
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    unique case (mode)
      MODE_A: res = a;
      MODE_B: res = b;
      MODE_ADD, MODE_SUB, MODE_ACC_ADD, MODE_ACC_SUB: begin
        res   = ext[WIDTH-1:0];
        res_c = ext[WIDTH];
        res_v = ovf;
      end
      default: res = '0;
    endcase
  end

  shift_add_multiplier #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (mul_start),
    .a      (a),
    .b      (b),
    .done   (mul_done),
    .product(product)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      y         <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      acc       <= '0;
    end else if (state == ST_BUSY) begin
      if (mul_done) begin
        state     <= ST_IDLE;
        out_valid <= 1'b1;
        y         <= product[WIDTH-1:0];
        carry     <= |product[2*WIDTH-1:WIDTH];
        overflow  <= 1'b0;
      end
    end else if (accept) begin
      if (mode == MODE_MUL) begin
        state     <= ST_BUSY;
        out_valid <= 1'b0;
      end else begin
        out_valid <= 1'b1;
        y         <= res;
        carry     <= res_c;
        overflow  <= res_v;
        if (mode == MODE_ACC_ADD || mode == MODE_ACC_SUB)
          acc <= res;
        else if (mode == MODE_CLR)
          acc <= '0;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
